// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - runtime-programmable raster timing generator
// Shadowed per-frame timing, look-ahead pixel request, counted or continuous frames.
module video_timing_gen #(
    parameter int PW        = 10,
    parameter int NCH       = 3,
    parameter int CW        = 12,
    parameter int RD_LAT    = 1,
    parameter int VSYNC_POL = 0,
    parameter int HSYNC_POL = 0
) (
    input  logic                pclk,
    input  logic                rst,
    input  logic                i_start,
    input  logic                i_stop,
    input  logic [15:0]         i_frames,
    input  logic [CW-1:0]       i_hsw,
    input  logic [CW-1:0]       i_hbp,
    input  logic [CW-1:0]       i_hact,
    input  logic [CW-1:0]       i_hfp,
    input  logic [CW-1:0]       i_vsw,
    input  logic [CW-1:0]       i_vbp,
    input  logic [CW-1:0]       i_vact,
    input  logic [CW-1:0]       i_vfp,
    input  logic [NCH*PW-1:0]   i_pix,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_cfg_err,
    output logic                o_frame_start,
    output logic [15:0]         o_frame_cnt,
    output logic                o_req,
    output logic                o_vsync,
    output logic                o_hsync,
    output logic                o_de,
    output logic [NCH*PW-1:0]   o_pix,
    output logic [CW-1:0]       o_x,
    output logic [CW-1:0]       o_y
);
    localparam int   TW   = CW + 2;
    localparam logic HPOL = (HSYNC_POL != 0);
    localparam logic VPOL = (VSYNC_POL != 0);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOP_PEND} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  hsw_q, hbp_q, hact_q, hfp_q, vsw_q, vbp_q, vact_q, vfp_q;
    logic [CW-1:0]  hsw_d, hbp_d, hact_d, hfp_d, vsw_d, vbp_d, vact_d, vfp_d;
    logic [15:0]    frames_q, frames_d;
    logic [15:0]    frame_cnt_q, frame_cnt_d;
    logic [TW-1:0]  h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic           done_q, done_d, cfg_err_q, cfg_err_d;

    logic [TW-1:0]  htot, vtot, h_start, h_end, v_start, v_end, h_ahead;
    logic           busy, h_last, v_last, frame_last, finish, cfg_ok, load_shadow;
    logic           v_active, de, req;

    assign htot = {2'b00, hsw_q} + {2'b00, hbp_q} + {2'b00, hact_q} + {2'b00, hfp_q};
    assign vtot = {2'b00, vsw_q} + {2'b00, vbp_q} + {2'b00, vact_q} + {2'b00, vfp_q};

    assign busy       = (state_q != S_IDLE);
    assign h_last     = (h_cnt_q == htot - TW'(1));
    assign v_last     = (v_cnt_q == vtot - TW'(1));
    assign frame_last = busy && h_last && v_last;
    // A stop arriving on the very last cycle still ends this frame.
    assign finish     = (state_q == S_STOP_PEND) || i_stop ||
                        ((frames_q != 16'd0) && (frame_cnt_q == frames_q - 16'd1));

    assign cfg_ok = (i_hsw != '0) && (i_hbp != '0) && (i_hact != '0) && (i_hfp != '0) &&
                    (i_vsw != '0) && (i_vbp != '0) && (i_vact != '0) && (i_vfp != '0) &&
                    (({2'b00, i_hsw} + {2'b00, i_hbp}) >= TW'(RD_LAT));

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        h_cnt_d     = h_cnt_q;
        v_cnt_d     = v_cnt_q;
        done_d      = 1'b0;
        cfg_err_d   = 1'b0;
        load_shadow = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    if (cfg_ok) begin
                        state_d     = S_RUN;
                        load_shadow = 1'b1;
                        frame_cnt_d = 16'd0;
                        h_cnt_d     = '0;
                        v_cnt_d     = '0;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            default: begin
                if (i_stop) begin
                    state_d = S_STOP_PEND;
                end
                if (frame_last) begin
                    h_cnt_d = '0;
                    v_cnt_d = '0;
                    if (finish) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        load_shadow = 1'b1;
                    end
                end else if (h_last) begin
                    h_cnt_d = '0;
                    v_cnt_d = v_cnt_q + TW'(1);
                end else begin
                    h_cnt_d = h_cnt_q + TW'(1);
                end
            end
        endcase

        hsw_d = hsw_q; hbp_d = hbp_q; hact_d = hact_q; hfp_d = hfp_q;
        vsw_d = vsw_q; vbp_d = vbp_q; vact_d = vact_q; vfp_d = vfp_q;
        frames_d = frames_q;
        if (load_shadow) begin
            hsw_d = i_hsw; hbp_d = i_hbp; hact_d = i_hact; hfp_d = i_hfp;
            vsw_d = i_vsw; vbp_d = i_vbp; vact_d = i_vact; vfp_d = i_vfp;
            frames_d = i_frames;
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            hsw_q       <= '0;
            hbp_q       <= '0;
            hact_q      <= '0;
            hfp_q       <= '0;
            vsw_q       <= '0;
            vbp_q       <= '0;
            vact_q      <= '0;
            vfp_q       <= '0;
            frames_q    <= '0;
            frame_cnt_q <= '0;
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hsw_q       <= hsw_d;
            hbp_q       <= hbp_d;
            hact_q      <= hact_d;
            hfp_q       <= hfp_d;
            vsw_q       <= vsw_d;
            vbp_q       <= vbp_d;
            vact_q      <= vact_d;
            vfp_q       <= vfp_d;
            frames_q    <= frames_d;
            frame_cnt_q <= frame_cnt_d;
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            done_q      <= done_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign h_start  = {2'b00, hsw_q} + {2'b00, hbp_q};
    assign h_end    = h_start + {2'b00, hact_q};
    assign v_start  = {2'b00, vsw_q} + {2'b00, vbp_q};
    assign v_end    = v_start + {2'b00, vact_q};
    assign h_ahead  = h_cnt_q + TW'(RD_LAT);
    assign v_active = (v_cnt_q >= v_start) && (v_cnt_q < v_end);
    assign de       = busy && v_active && (h_cnt_q >= h_start) && (h_cnt_q < h_end);
    // Request window is the active window shifted earlier by the read latency.
    assign req      = busy && v_active && (h_ahead >= h_start) && (h_ahead < h_end);

    assign o_busy        = busy;
    assign o_done        = done_q;
    assign o_cfg_err     = cfg_err_q;
    assign o_frame_start = busy && (h_cnt_q == '0) && (v_cnt_q == '0);
    assign o_frame_cnt   = frame_cnt_q;
    assign o_req         = req;
    assign o_de          = de;
    assign o_hsync       = (busy && (h_cnt_q < {2'b00, hsw_q})) ^ HPOL;
    assign o_vsync       = (busy && (v_cnt_q < {2'b00, vsw_q})) ^ VPOL;
    assign o_pix         = de ? i_pix : '0;
    assign o_x           = de ? CW'(h_cnt_q - h_start) : '0;
    assign o_y           = de ? CW'(v_cnt_q - v_start) : '0;
endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - self-checking bench for video_timing_gen
// Three instances: RD_LAT 1/2/3, the RD_LAT=2 one with inverted sync polarity.
module tb_video_timing_gen;
    typedef struct packed {
        logic [11:0] hsw, hbp, hact, hfp, vsw, vbp, vact, vfp;
    } cfg_t;

    typedef struct {
        int   s;
        cfg_t c;
        int   ok;
    } vec_t;

    logic        pclk = 1'b0;
    logic        rst, i_start, i_stop;
    logic [15:0] i_frames;
    cfg_t        cur;
    logic [29:0] pix_i [3];
    logic        busy_o [3], done_o [3], err_o [3], fs_o [3], req_o [3];
    logic        vs_o [3], hs_o [3], de_o [3];
    logic [15:0] fc_o [3];
    logic [29:0] pix_o [3];
    logic [11:0] x_o [3], y_o [3];
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 pclk = ~pclk;

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_dut
            video_timing_gen #(
                .PW(10), .NCH(3), .CW(12), .RD_LAT(g + 1),
                .VSYNC_POL(g == 1 ? 1 : 0), .HSYNC_POL(g == 1 ? 1 : 0)
            ) u_dut (
                .pclk(pclk), .rst(rst), .i_start(i_start), .i_stop(i_stop),
                .i_frames(i_frames),
                .i_hsw(cur.hsw), .i_hbp(cur.hbp), .i_hact(cur.hact), .i_hfp(cur.hfp),
                .i_vsw(cur.vsw), .i_vbp(cur.vbp), .i_vact(cur.vact), .i_vfp(cur.vfp),
                .i_pix(pix_i[g]),
                .o_busy(busy_o[g]), .o_done(done_o[g]), .o_cfg_err(err_o[g]),
                .o_frame_start(fs_o[g]), .o_frame_cnt(fc_o[g]), .o_req(req_o[g]),
                .o_vsync(vs_o[g]), .o_hsync(hs_o[g]), .o_de(de_o[g]),
                .o_pix(pix_o[g]), .o_x(x_o[g]), .o_y(y_o[g])
            );
        end
    endgenerate

    function automatic cfg_t mk(int a, int b, int c, int d, int e, int f, int gg, int h);
        cfg_t r;
        r.hsw = 12'(a); r.hbp = 12'(b); r.hact = 12'(c); r.hfp = 12'(d);
        r.vsw = 12'(e); r.vbp = 12'(f); r.vact = 12'(gg); r.vfp = 12'(h);
        return r;
    endfunction

    function automatic int ht(cfg_t c);
        return int'(c.hsw) + int'(c.hbp) + int'(c.hact) + int'(c.hfp);
    endfunction

    function automatic int vt(cfg_t c);
        return int'(c.vsw) + int'(c.vbp) + int'(c.vact) + int'(c.vfp);
    endfunction

    function automatic logic ok_of(cfg_t c, int lat);
        return (c.hsw != 0) && (c.hbp != 0) && (c.hact != 0) && (c.hfp != 0) &&
               (c.vsw != 0) && (c.vbp != 0) && (c.vact != 0) && (c.vfp != 0) &&
               (int'(c.hsw) + int'(c.hbp) >= lat);
    endfunction

    // Expected outputs from the raster position r cycles into the current frame.
    function automatic logic [95:0] model_vec(cfg_t c, int lat, logic pol, logic busy,
                                              logic done, logic err, int r, int fc);
        int h, v, hs, vsv, x, y;
        logic va, de, rq, hsy, vsy;
        if (!busy)
            return {16'h0, 1'b0, done, err, 1'b0, 1'b0, pol, pol, 1'b0, 12'h0, 12'h0,
                    16'h0, 30'h0};
        h   = r % ht(c);
        v   = r / ht(c);
        hs  = int'(c.hsw) + int'(c.hbp);
        vsv = int'(c.vsw) + int'(c.vbp);
        va  = (v >= vsv) && (v < vsv + int'(c.vact));
        de  = va && (h >= hs) && (h < hs + int'(c.hact));
        rq  = va && (h + lat >= hs) && (h + lat < hs + int'(c.hact));
        hsy = (h < int'(c.hsw)) ^ pol;
        vsy = (v < int'(c.vsw)) ^ pol;
        x   = de ? h - hs : 0;
        y   = de ? v - vsv : 0;
        return {16'h0, 1'b1, done, err, (r == 0), rq, hsy, vsy, de, 12'(x), 12'(y),
                16'(fc), 30'(x)};
    endfunction

    function automatic logic [95:0] act_vec(int s, logic show_fc);
        return {16'h0, busy_o[s], done_o[s], err_o[s], fs_o[s], req_o[s], hs_o[s], vs_o[s],
                de_o[s], x_o[s], y_o[s], show_fc ? fc_o[s] : 16'h0, pix_o[s]};
    endfunction

    task automatic chk(input string nm, input logic [95:0] a, input logic [95:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; i_start = 1'b0; i_stop = 1'b0;
        repeat (2) @(negedge pclk);
        rst = 1'b0;
    endtask

    task automatic run(input int s, input int nfr, input int stop_k, input int chg_k,
                       input cfg_t chg, input int rst_k, input int st_k,
                       output int busy_n, output int de_n, output int done_k,
                       output int max_fc, output int err_n);
        int   lat, fs, mf, idle_n, lc;
        logic pol, m_busy, m_stop, e_done, e_err;
        cfg_t mcfg;
        logic hv [5];
        int   hi [5];
        lat = s + 1; pol = (s == 1);
        busy_n = 0; de_n = 0; done_k = 0; max_fc = 0; err_n = 0;
        m_stop = 0; idle_n = 0; lc = 0;
        for (int j = 0; j < 5; j++) begin hv[j] = 0; hi[j] = 0; end
        i_frames = 16'(nfr);
        @(negedge pclk);
        i_start = 1'b1;
        m_busy = ok_of(cur, lat); fs = 1; mf = 0; mcfg = cur;
        for (int k = 1; k < 4000; k++) begin
            @(negedge pclk);
            i_start = 1'b0; i_stop = 1'b0; rst = 1'b0;
            e_done = 0;
            e_err  = (k == 1) && !m_busy;
            if (rst_k != 0 && k == rst_k + 1) begin
                m_busy = 0;
            end else if (m_busy && (k - fs == ht(mcfg) * vt(mcfg))) begin
                if (m_stop || (nfr != 0 && mf == nfr - 1)) begin
                    m_busy = 0; e_done = 1;
                end else begin
                    mf++; fs = k; mcfg = cur;
                end
            end
            chk($sformatf("s%0d_cycle%0d", s, k), act_vec(s, m_busy),
                model_vec(mcfg, lat, pol, m_busy, e_done, e_err, k - fs, mf));
            if (busy_o[s]) busy_n++;
            if (de_o[s]) de_n++;
            if (err_o[s]) err_n++;
            if (done_o[s] && done_k == 0) done_k = k;
            if (busy_o[s] && int'(fc_o[s]) > max_fc) max_fc = int'(fc_o[s]);
            for (int j = 4; j > 0; j--) begin hv[j] = hv[j-1]; hi[j] = hi[j-1]; end
            hv[0] = req_o[s];
            hi[0] = req_o[s] ? lc : 0;
            lc = req_o[s] ? lc + 1 : 0;
            pix_i[s] = hv[lat-1] ? 30'(hi[lat-1]) : 30'h2AAAAAAA;
            if (k == chg_k) cur = chg;
            if (k == stop_k && m_busy) begin i_stop = 1'b1; m_stop = 1; end
            if (k == rst_k) rst = 1'b1;
            if (k == st_k) i_start = 1'b1;
            if (!m_busy) begin
                idle_n++;
                if (idle_n >= 3) break;
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [6];
        cfg_t basic, c2;
        int bn, dn, dk, mfc, en, nfr, l0, stk, chk_k, stp;
        for (int j = 0; j < 3; j++) pix_i[j] = '0;
        basic = mk(1, 2, 10, 1, 1, 1, 4, 1);
        cur = basic; i_frames = 16'd0;
        do_reset();
        for (int s = 0; s < 3; s++)
            chk($sformatf("reset_state_s%0d", s), act_vec(s, 1'b1),
                {16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, (s == 1), (s == 1), 1'b0,
                 12'h0, 12'h0, 16'h0, 30'h0});

        tbl[0] = '{0, mk(1, 2, 10, 1, 1, 1, 0, 1), 0};
        tbl[1] = '{0, mk(1, 2, 10, 1, 1, 1, 4, 1), 1};
        tbl[2] = '{2, mk(1, 1, 10, 1, 1, 1, 4, 1), 0};
        tbl[3] = '{2, mk(1, 2, 10, 1, 1, 1, 4, 1), 1};
        tbl[4] = '{1, mk(0, 5, 4, 1, 1, 1, 2, 1), 0};
        tbl[5] = '{0, mk(1, 1, 4, 1, 1, 1, 2, 0), 0};
        for (int i = 0; i < 6; i++) begin
            do_reset();
            cur = tbl[i].c;
            run(tbl[i].s, 1, 0, 0, cur, 2, 0, bn, dn, dk, mfc, en);
            chk($sformatf("cfg_err_count_%0d", i), 96'(en), 96'(tbl[i].ok ? 0 : 1));
            chk($sformatf("cfg_busy_count_%0d", i), 96'(bn), 96'(tbl[i].ok ? 2 : 0));
        end

        do_reset(); cur = basic;
        run(0, 2, 0, 0, basic, 0, 0, bn, dn, dk, mfc, en);
        chk("basic_busy_cycles", 96'(bn), 96'(196));
        chk("basic_de_cycles", 96'(dn), 96'(80));
        chk("basic_done_cycle", 96'(dk), 96'(197));
        chk("basic_max_frame", 96'(mfc), 96'(1));

        do_reset(); cur = basic;
        run(0, 0, 335, 0, basic, 0, 0, bn, dn, dk, mfc, en);
        chk("stop_busy_cycles", 96'(bn), 96'(392));
        chk("stop_done_cycle", 96'(dk), 96'(393));
        chk("stop_max_frame", 96'(mfc), 96'(3));

        do_reset(); cur = basic;
        run(0, 2, 0, 30, mk(1, 2, 6, 1, 1, 1, 4, 1), 0, 0, bn, dn, dk, mfc, en);
        chk("reprog_busy_cycles", 96'(bn), 96'(168));
        chk("reprog_de_cycles", 96'(dn), 96'(64));

        do_reset(); cur = basic;
        run(1, 1, 0, 0, basic, 0, 0, bn, dn, dk, mfc, en);
        chk("lat2_busy_cycles", 96'(bn), 96'(98));
        chk("lat2_de_cycles", 96'(dn), 96'(40));
        chk("lat2_done_cycle", 96'(dk), 96'(99));

        do_reset(); cur = basic;
        run(0, 2, 0, 0, basic, 34, 0, bn, dn, dk, mfc, en);
        chk("rst_busy_cycles", 96'(bn), 96'(34));
        chk("rst_no_done", 96'(dk), 96'(0));
        run(0, 1, 0, 0, basic, 0, 0, bn, dn, dk, mfc, en);
        chk("restart_busy_cycles", 96'(bn), 96'(98));
        chk("restart_done_cycle", 96'(dk), 96'(99));

        for (int i = 0; i < 6; i++) begin
            int s, lat;
            s   = i % 3;
            lat = s + 1;
            cur = mk($urandom_range(1, 2), $urandom_range(lat, lat + 2), $urandom_range(1, 6),
                     $urandom_range(1, 2), $urandom_range(1, 2), $urandom_range(1, 2),
                     $urandom_range(1, 5), $urandom_range(1, 2));
            c2  = mk($urandom_range(1, 2), $urandom_range(lat, lat + 2), $urandom_range(1, 6),
                     $urandom_range(1, 2), $urandom_range(1, 2), $urandom_range(1, 2),
                     $urandom_range(1, 5), $urandom_range(1, 2));
            l0    = ht(cur) * vt(cur);
            nfr   = $urandom_range(0, 3);
            stp   = (nfr == 0 || $urandom_range(0, 1) == 1) ? $urandom_range(2, l0) : 0;
            chk_k = $urandom_range(2, l0 - 1);
            stk   = $urandom_range(2, 10);
            do_reset();
            run(s, nfr, stp, chk_k, c2, 0, stk, bn, dn, dk, mfc, en);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Runtime-programmable raster timing generator. It produces hsync/vsync/DE, the pixel coordinates, and a look-ahead pixel request for an upstream line buffer or scaler.
- It generalises the fixed-parameter timing FSM with:
  - per-frame timing registers latched at frame boundaries,
  - N-channel pixel width,
  - continuous or counted-frame mode with graceful stop,
  - configuration error detection.
- It sits between the scaler output buffer and the panel interface.

Parameters:
- PW, 10, bits per colour channel
- NCH, 3, number of colour channels
- CW, 12, width of timing fields and of the x/y counters
- RD_LAT, 1, cycles by which o_req leads o_de (0..4)
- VSYNC_POL, 0, 0 = vsync active-high, 1 = active-low
- HSYNC_POL, 0, 0 = hsync active-high, 1 = active-low

Ports:
- pclk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- i_start  in  1  begin generation (sampled only while idle)
- i_stop  in  1  request stop at end of current frame (sticky until frame end)
- i_frames  in  16  frame count; 0 = continuous
- i_hsw, i_hbp, i_hact, i_hfp  in  CW each  horizontal sync, back porch, active and front porch lengths (pixels)
- i_vsw, i_vbp, i_vact, i_vfp  in  CW each  vertical sync, back porch, active and front porch lengths (lines)
- i_pix  in  NCH*PW  upstream pixel, valid RD_LAT cycles after o_req
- o_busy  out  1  generation in progress
- o_done  out  1  1-cycle pulse: all frames sent or stop honoured
- o_cfg_err  out  1  1-cycle pulse: start rejected, illegal config
- o_frame_start  out  1  1-cycle pulse on first cycle of each frame
- o_frame_cnt  out  16  index of current frame (0-based)
- o_req  out  1  pixel request, look-ahead of DE
- o_vsync, o_hsync, o_de  out  1 each  raster controls
- o_pix  out  NCH*PW  i_pix while o_de, else 0
- o_x, o_y  out  CW each  active-area coordinates while o_de, else 0

Behaviour:
- Reset (rst high at pclk edge):
  - o_busy, o_done, o_cfg_err, o_frame_start, o_req and o_de = 0.
  - Counters and frame_cnt = 0; stop flag cleared.
  - Syncs at inactive level per polarity.
  - rst mid-frame aborts immediately; no o_done.
- Shadow config: the 8 timing fields plus i_frames are latched into shadow registers on an accepted start and at every frame wrap. Mid-frame input changes take effect on the next frame only.
- Derived totals: HTOT = hsw+hbp+hact+hfp; VTOT = vsw+vbp+vact+vfp. Totals are computed at CW+2 bits; no overflow.
- Start legality:
  - Idle + i_start with any timing field = 0, or hsw+hbp < RD_LAT: o_cfg_err pulses next cycle, block stays idle.
  - Otherwise o_busy = 1 next cycle with h_cnt = v_cnt = 0, frame_cnt = 0.
  - i_start while busy is ignored.
- FSM states: IDLE, RUN, and STOP_PEND (RUN with stop flag set).
  - i_stop in RUN -> STOP_PEND.
  - i_stop while idle is ignored.
- Counters:
  - h_cnt runs 0..HTOT-1; v_cnt increments when h_cnt wraps.
  - Last cycle of a frame is h_cnt = HTOT-1, v_cnt = VTOT-1.
  - At that cycle, if STOP_PEND, or i_frames != 0 and frame_cnt == i_frames-1:
    - o_busy <= 0, o_done <= 1, state IDLE, counters 0.
  - Else: frame_cnt <= frame_cnt+1 (16-bit wrap in continuous mode), reload shadows, counters 0.
  - A stop raised on the last cycle of a frame is honoured at that same boundary.
- Decoding (combinational from registered counters and shadows; 0/inactive when idle):
  - hsync_int = h_cnt < hsw.
  - vsync_int = v_cnt < vsw.
  - de = h_cnt in [hsw+hbp, hsw+hbp+hact) and v_cnt in [vsw+vbp, vsw+vbp+vact).
  - o_hsync = hsync_int XOR HSYNC_POL; o_vsync likewise with VSYNC_POL.
- o_req: asserted when an active line has h_cnt+RD_LAT inside the horizontal active range. It leads o_de by exactly RD_LAT cycles and gives hact requests per active line. With RD_LAT = 0, o_req = o_de.
- Coordinates and frame start:
  - o_x = h_cnt-(hsw+hbp) and o_y = v_cnt-(vsw+vbp) while o_de.
  - o_frame_start = busy and h_cnt = 0 and v_cnt = 0.
- Cycle accounting: busy lasts exactly HTOT*VTOT*frames cycles. o_done is asserted in the cycle o_busy first reads 0.

Test Plan:
- Basic counted run:
  - Stimulus: h = 1/2/10/1, v = 1/1/4/1, frames = 2, RD_LAT = 1.
  - Required: HTOT = 14, VTOT = 7; o_busy high for 196 cycles; 40 DE cycles per frame; o_x runs 0..9 and o_y 0..3; o_done pulses once at cycle 197; o_frame_start at cycles 1 and 99.
- Continuous mode with stop:
  - Stimulus: frames = 0, i_stop pulsed in mid frame 3.
  - Required: o_done after the last cycle of frame index 3; no partial frame; o_frame_cnt reaches 3.
- Mid-frame reprogramming:
  - Stimulus: change hact 10 -> 6 mid frame 0.
  - Required: frame 0 keeps 10-pixel lines; frame 1 has 6-pixel lines, HTOT = 10.
- Illegal configuration:
  - Stimulus: i_vact = 0 with start.
  - Required: o_cfg_err pulses, o_busy stays 0.
  - Stimulus: hsw = 1, hbp = 1 with RD_LAT = 3.
  - Required: o_cfg_err pulses.
- Request look-ahead and polarity:
  - Stimulus: RD_LAT = 2; i_pix driven as the 2-cycle-delayed request index; VSYNC_POL = 1, HSYNC_POL = 1.
  - Required: o_req rises 2 cycles before o_de; o_pix sequence equals 0..9 per line; syncs low when active, high when idle.
- Reset behaviour:
  - Stimulus: rst asserted mid-active-line, then start reissued.
  - Required: all outputs inactive the next cycle; no o_done; restart begins at h = v = 0, frame_cnt = 0.
